// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and score limits for the CNN result stage.
package cnn_pkg;

   localparam int unsigned NUM_CLASSES = 10;
   localparam int unsigned SCORE_W     = 113;
   localparam int unsigned IDX_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

endpackage

// File: rtl/argmax_update_cell.sv
// One step of the running top-1 (and, with CNN_ARGMAX_MARGIN_EN, top-2) scan.
module argmax_update_cell #(
   parameter int unsigned SCORE_W = 113,
   parameter int unsigned IDX_W   = 4
) (
   input  logic [SCORE_W-1:0] cand,
   input  logic [IDX_W-1:0]   cand_idx,
   input  logic [SCORE_W-1:0] best,
   input  logic [IDX_W-1:0]   idx,
`ifdef CNN_ARGMAX_MARGIN_EN
   input  logic [SCORE_W-1:0] second,
   output logic [SCORE_W-1:0] second_nxt,
`endif
   output logic [SCORE_W-1:0] best_nxt,
   output logic [IDX_W-1:0]   idx_nxt
);

   always_comb begin
      best_nxt   = best;
      idx_nxt    = idx;
`ifdef CNN_ARGMAX_MARGIN_EN
      second_nxt = second;
`endif
      // Strict compare: on a tie the earlier class keeps the lead.
      if ($signed(cand) > $signed(best)) begin
         best_nxt   = cand;
         idx_nxt    = cand_idx;
`ifdef CNN_ARGMAX_MARGIN_EN
         second_nxt = best;
      end else if ($signed(cand) > $signed(second)) begin
         second_nxt = cand;
`endif
      end
   end

endmodule

// File: rtl/cnn_result_argmax.sv
// Sequential top-1 classifier over simpleCNN scores, one class per clock.
// Optional margin/low_conf outputs are enabled by defining CNN_ARGMAX_MARGIN_EN.
module cnn_result_argmax #(
   parameter int unsigned         NUM_CLASSES   = cnn_pkg::NUM_CLASSES,
   parameter int unsigned         SCORE_W       = cnn_pkg::SCORE_W,
   parameter int unsigned         IDX_W         = cnn_pkg::IDX_W,
   parameter logic [SCORE_W:0]    MARGIN_THRESH = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [IDX_W-1:0]               class_idx,
   output logic [SCORE_W-1:0]             max_score,
`ifdef CNN_ARGMAX_MARGIN_EN
   output logic [SCORE_W:0]               margin,
   output logic                           low_conf,
`endif
   output logic [15:0]                    frame_cnt
);

   import cnn_pkg::*;

   localparam logic [SCORE_W-1:0] SCORE_MIN_W = {1'b1, {(SCORE_W-1){1'b0}}};

   state_e                         state_q, state_d;
   logic [NUM_CLASSES*SCORE_W-1:0] scores_q, scores_d;
   logic [IDX_W-1:0]               k_q, k_d, idx_q, idx_d, class_idx_q, class_idx_d;
   logic [SCORE_W-1:0]             best_q, best_d, max_score_q, max_score_d;
   logic                           in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [15:0]                    frame_cnt_q, frame_cnt_d;
   logic [SCORE_W-1:0]             cand, nbest;
   logic [IDX_W-1:0]               nidx;
`ifdef CNN_ARGMAX_MARGIN_EN
   logic [SCORE_W-1:0]             second_q, second_d, nsecond;
   logic [SCORE_W:0]               margin_q, margin_d, margin_w;
   logic                           low_conf_q, low_conf_d;
`endif

   assign cand = scores_q[k_q*SCORE_W +: SCORE_W];

   argmax_update_cell #(
      .SCORE_W (SCORE_W),
      .IDX_W   (IDX_W)
   ) u_cell (
      .cand       (cand),
      .cand_idx   (k_q),
      .best       (best_q),
      .idx        (idx_q),
`ifdef CNN_ARGMAX_MARGIN_EN
      .second     (second_q),
      .second_nxt (nsecond),
`endif
      .best_nxt   (nbest),
      .idx_nxt    (nidx)
   );

`ifdef CNN_ARGMAX_MARGIN_EN
   // Sign-extend both operands so best - second can never overflow.
   assign margin_w = {nbest[SCORE_W-1], nbest} - {nsecond[SCORE_W-1], nsecond};
`endif

   always_comb begin
      state_d     = state_q;
      scores_d    = scores_q;
      k_d         = k_q;
      idx_d       = idx_q;
      best_d      = best_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      class_idx_d = class_idx_q;
      max_score_d = max_score_q;
      frame_cnt_d = frame_cnt_q;
`ifdef CNN_ARGMAX_MARGIN_EN
      second_d    = second_q;
      margin_d    = margin_q;
      low_conf_d  = low_conf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               scores_d   = scores;
               best_d     = scores[SCORE_W-1:0];
               idx_d      = '0;
               k_d        = IDX_W'(1);
               in_ready_d = 1'b0;
               state_d    = ST_SCAN;
`ifdef CNN_ARGMAX_MARGIN_EN
               second_d   = SCORE_MIN_W;
`endif
            end
         end
         ST_SCAN: begin
            best_d = nbest;
            idx_d  = nidx;
            k_d    = k_q + IDX_W'(1);
`ifdef CNN_ARGMAX_MARGIN_EN
            second_d = nsecond;
`endif
            // Last class: publish the result on the same edge it is resolved.
            if (k_q == IDX_W'(NUM_CLASSES-1)) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               class_idx_d = nidx;
               max_score_d = nbest;
`ifdef CNN_ARGMAX_MARGIN_EN
               margin_d    = margin_w;
               low_conf_d  = (margin_w <= MARGIN_THRESH);
`endif
            end
         end
         ST_DONE: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               frame_cnt_d = frame_cnt_q + 16'd1;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         scores_q    <= '0;
         k_q         <= '0;
         idx_q       <= '0;
         best_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         class_idx_q <= '0;
         max_score_q <= '0;
         frame_cnt_q <= '0;
`ifdef CNN_ARGMAX_MARGIN_EN
         second_q    <= '0;
         margin_q    <= '0;
         low_conf_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         scores_q    <= scores_d;
         k_q         <= k_d;
         idx_q       <= idx_d;
         best_q      <= best_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         class_idx_q <= class_idx_d;
         max_score_q <= max_score_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef CNN_ARGMAX_MARGIN_EN
         second_q    <= second_d;
         margin_q    <= margin_d;
         low_conf_q  <= low_conf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign class_idx = class_idx_q;
   assign max_score = max_score_q;
   assign frame_cnt = frame_cnt_q;
`ifdef CNN_ARGMAX_MARGIN_EN
   assign margin    = margin_q;
   assign low_conf  = low_conf_q;
`endif

endmodule

// File: tb/tb_cnn_result_argmax.sv
// Directed table-driven bench for cnn_result_argmax plus backpressure, reset and wrap sequences.
module tb_cnn_result_argmax;

   localparam int NC = 10;
   localparam int SW = 113;

   typedef struct {
      logic [NC*SW-1:0] scores;
      logic [3:0]       exp_idx;
      logic [SW-1:0]    exp_max;
      logic [SW:0]      exp_margin;
      logic             exp_low;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [NC*SW-1:0] scores = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [3:0]       class_idx;
   logic [SW-1:0]    max_score;
   logic [15:0]      frame_cnt;
`ifdef CNN_ARGMAX_MARGIN_EN
   logic [SW:0]      margin;
   logic             low_conf;
`endif

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_cnt = '0;
   vec_t vecs[5];

   always #5 clk = ~clk;

   cnn_result_argmax #(
      .NUM_CLASSES   (10),
      .SCORE_W       (113),
      .IDX_W         (4),
      .MARGIN_THRESH (114'd5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .scores    (scores),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .class_idx (class_idx),
      .max_score (max_score),
`ifdef CNN_ARGMAX_MARGIN_EN
      .margin    (margin),
      .low_conf  (low_conf),
`endif
      .frame_cnt (frame_cnt)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic start_frame(input logic [NC*SW-1:0] s);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("in_ready_wait", 128'(ok), 128'(1));
      scores   = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scores   = ~s;
      check("in_ready_after_accept", 128'(in_ready), 128'(0));
   endtask

   task automatic finish_frame(input vec_t v);
      repeat (8) @(posedge clk);
      #1;
      check("out_valid_early", 128'(out_valid), 128'(0));
      @(posedge clk);
      #1;
      check("out_valid_at_a9", 128'(out_valid), 128'(1));
      check("class_idx", 128'(class_idx), 128'(v.exp_idx));
      check("max_score", 128'(max_score), 128'(v.exp_max));
`ifdef CNN_ARGMAX_MARGIN_EN
      check("margin", 128'(margin), 128'(v.exp_margin));
      check("low_conf", 128'(low_conf), 128'(v.exp_low));
`endif
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      exp_cnt   = exp_cnt + 16'd1;
      check("out_valid_after_hs", 128'(out_valid), 128'(0));
      check("frame_cnt", 128'(frame_cnt), 128'(exp_cnt));
      check("in_ready_after_hs", 128'(in_ready), 128'(1));
   endtask

   initial begin
      // Table: distinct, all-negative, tie, extreme span, all most-negative.
      for (int k = 0; k < NC; k++) begin
         vecs[0].scores[k*SW +: SW] = (k == 7) ? 113'd1000 : 113'(k * 10);
         vecs[1].scores[k*SW +: SW] = 113'(-(k + 1) * 5);
         vecs[2].scores[k*SW +: SW] = (k == 3 || k == 8) ? (113'd1 << 100) : '0;
         vecs[3].scores[k*SW +: SW] = (k == 9) ? {1'b0, {(SW-1){1'b1}}} : cnn_pkg::SCORE_MIN;
         vecs[4].scores[k*SW +: SW] = cnn_pkg::SCORE_MIN;
      end
      vecs[0].exp_idx = 4'd7; vecs[0].exp_max = 113'd1000;   vecs[0].exp_margin = 114'd910; vecs[0].exp_low = 1'b0;
      vecs[1].exp_idx = 4'd0; vecs[1].exp_max = 113'(-5);    vecs[1].exp_margin = 114'd5;   vecs[1].exp_low = 1'b1;
      vecs[2].exp_idx = 4'd3; vecs[2].exp_max = 113'd1 << 100; vecs[2].exp_margin = '0;     vecs[2].exp_low = 1'b1;
      vecs[3].exp_idx = 4'd9; vecs[3].exp_max = {1'b0, {(SW-1){1'b1}}};
      vecs[3].exp_margin = {1'b0, {SW{1'b1}}}; vecs[3].exp_low = 1'b0;
      vecs[4].exp_idx = 4'd0; vecs[4].exp_max = cnn_pkg::SCORE_MIN; vecs[4].exp_margin = '0; vecs[4].exp_low = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_frame_cnt", 128'(frame_cnt), 128'(0));
      check("rst_class_idx", 128'(class_idx), 128'(0));
      check("rst_max_score", 128'(max_score), 128'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", 128'(in_ready), 128'(1));

      for (int i = 0; i < 5; i++) begin
         start_frame(vecs[i].scores);
         finish_frame(vecs[i]);
         handshake();
      end

      // Backpressure: result held 20 cycles, a new frame offered meanwhile is dropped.
      start_frame(vecs[0].scores);
      finish_frame(vecs[0]);
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin
            in_valid = 1'b1;
            scores   = vecs[1].scores;
         end
         @(posedge clk);
         #1;
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_class_idx", 128'(class_idx), 128'(vecs[0].exp_idx));
         check("bp_max_score", 128'(max_score), 128'(vecs[0].exp_max));
         check("bp_in_ready", 128'(in_ready), 128'(0));
      end
      in_valid = 1'b0;
      check("bp_frame_cnt_held", 128'(frame_cnt), 128'(exp_cnt));
      handshake();
      begin
         bit seen = 1'b0;
         repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
         end
         check("bp_ignored_frame", 128'(seen), 128'(0));
      end

      // Reset in the middle of a scan.
      start_frame(vecs[1].scores);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_in_ready", 128'(in_ready), 128'(0));
      check("midrst_frame_cnt", 128'(frame_cnt), 128'(0));
      check("midrst_class_idx", 128'(class_idx), 128'(0));
      check("midrst_max_score", 128'(max_score), 128'(0));
      exp_cnt = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_in_ready_back", 128'(in_ready), 128'(1));
      check("midrst_no_out", 128'(out_valid), 128'(0));
      start_frame(vecs[2].scores);
      finish_frame(vecs[2]);
      handshake();

      // Counter wrap.
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt_q;
      #1;
      check("wrap_preload", 128'(frame_cnt), 128'(16'hFFFF));
      exp_cnt = 16'hFFFF;
      start_frame(vecs[0].scores);
      finish_frame(vecs[0]);
      handshake();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
